// File: rtl/rf_uart_dump_pkg.sv
// Shared constants, FSM encoding and hex helper for the register-file UART dumper.
package rf_uart_dump_pkg;

  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_HEX0 = 8'h30;
  localparam logic [7:0] ASCII_HEXA = 8'h41;

  localparam logic [3:0] LAST_BYTE_IDX = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_NEXT
  } dump_state_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_HEX0 + {4'h0, n};
    else           return ASCII_HEXA + {4'h0, n - 4'd10};
  endfunction

endpackage

// File: rtl/dump_uart_tx.sv
// 8N1 UART serializer; ready rises in the final stop-bit cycle so bytes can be chained with no gap.
module dump_uart_tx #(
  parameter int DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic          active;
  logic          bit_end;

  assign bit_end = (baud_cnt == BW'(DIV - 1));
  assign ready   = !active || (bit_end && (bit_cnt == 4'd9));

  // tx is registered; bit_cnt names the bit on the line (0 start, 1..8 data, 9 stop)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
      shreg    <= '1;
      active   <= 1'b0;
      tx       <= 1'b1;
    end else if (valid && ready) begin
      baud_cnt <= '0;
      bit_cnt  <= 4'd0;
      shreg    <= {1'b1, data};
      active   <= 1'b1;
      tx       <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_uart_dump.sv
// Walks every register-file entry and prints "AA DDDD\r\n" per entry over UART.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | ra driven, RF settling
//   LATCH | rd captured into word, byte 0 handed to serializer
//   SEND  | bytes 1..8 chained as serializer frees up
//   NEXT  | advance address or finish with done
module rf_uart_dump
  import rf_uart_dump_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int AW     = 5,
  parameter int DW     = 16,
  parameter int DEPTH  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd,
  output logic          tx,
  output logic          busy,
  output logic          done
);

  localparam int DIV = CLK_HZ / BAUD;

  dump_state_t   state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [3:0]    byte_idx, idx_nxt;
  logic [DW-1:0] word;
  logic          load_word;
  logic          last_addr;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic [3:0]    sel_idx;
  logic [7:0]    addr8;

  assign ra        = addr;
  assign last_addr = (addr == AW'(DEPTH - 1));
  assign addr8     = 8'(addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr     <= '0;
      byte_idx <= 4'd0;
      word     <= '0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      byte_idx <= idx_nxt;
      if (load_word) word <= rd;
    end
  end

  // byte 0 is issued from LATCH; later bytes are issued one ahead of byte_idx
  always_comb begin
    sel_idx = (state == ST_LATCH) ? 4'd0 : byte_idx + 4'd1;
    case (sel_idx)
      4'd0:    tx_data = nibble_to_ascii(addr8[7:4]);
      4'd1:    tx_data = nibble_to_ascii(addr8[3:0]);
      4'd2:    tx_data = ASCII_SP;
      4'd3:    tx_data = nibble_to_ascii(word[15:12]);
      4'd4:    tx_data = nibble_to_ascii(word[11:8]);
      4'd5:    tx_data = nibble_to_ascii(word[7:4]);
      4'd6:    tx_data = nibble_to_ascii(word[3:0]);
      4'd7:    tx_data = ASCII_CR;
      default: tx_data = ASCII_LF;
    endcase
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    idx_nxt   = byte_idx;
    tx_valid  = 1'b0;
    load_word = 1'b0;
    done      = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
          addr_nxt  = '0;
        end
      end
      ST_FETCH: state_nxt = ST_LATCH;
      ST_LATCH: begin
        load_word = 1'b1;
        tx_valid  = 1'b1;
        idx_nxt   = 4'd0;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (byte_idx == LAST_BYTE_IDX) begin
            state_nxt = ST_NEXT;
          end else begin
            tx_valid = 1'b1;
            idx_nxt  = byte_idx + 4'd1;
          end
        end
      end
      ST_NEXT: begin
        if (last_addr) begin
          // busy drops with done so a held start is accepted right here
          done     = 1'b1;
          busy     = 1'b0;
          addr_nxt = '0;
          state_nxt = start ? ST_FETCH : ST_IDLE;
        end else begin
          addr_nxt  = addr + 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  dump_uart_tx #(.DIV(DIV)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .valid (tx_valid),
    .data  (tx_data),
    .ready (tx_ready),
    .tx    (tx)
  );

endmodule

// File: tb/tb_rf_uart_dump.sv
// Scoreboard bench: expected dump text is queued at start, a UART decoder pops and compares each byte.
module tb_rf_uart_dump;

  localparam int DIV       = 16;
  localparam int AW        = 5;
  localparam int DW        = 16;
  localparam int DEPTH     = 32;
  localparam int ENTRY_CYC = 9 * 10 * DIV + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic          tx, busy, done;
  logic [15:0]   rf [DEPTH];

  assign rd = rf[ra];

  rf_uart_dump #(.CLK_HZ(16), .BAUD(1), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ra    (ra),
    .rd    (rd),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] exp_q [$];
  string      hexs = "0123456789ABCDEF";
  int         rx_count = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         acc_cyc = 0;
  int         prev_start = 0;
  int         byte_in = 0;
  bit         expect_first = 1'b0;
  bit         dec_busy = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_sh = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic push_dump();
    logic [15:0] w;
    for (int a = 0; a < DEPTH; a++) begin
      w = rf[a];
      exp_q.push_back(hexs[(a >> 4) & 15]);
      exp_q.push_back(hexs[a & 15]);
      exp_q.push_back(8'h20);
      exp_q.push_back(hexs[w[15:12]]);
      exp_q.push_back(hexs[w[11:8]]);
      exp_q.push_back(hexs[w[7:4]]);
      exp_q.push_back(hexs[w[3:0]]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic wait_rx(input int n, input string tag);
    int budget;
    int t;
    budget = (n - rx_count) * 12 * DIV + 1000;
    t = 0;
    while (rx_count < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (rx_count < n) chk(tag, rx_count, n);
  endtask

  // UART decoder and done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", int'(busy), 0);
    end
    if (rst) begin
      dec_busy = 1'b0;
    end else if (!dec_busy) begin
      if (tx == 1'b0) begin
        dec_busy = 1'b1;
        dec_cnt  = 0;
        if (expect_first) begin
          chk("first_start_latency", cyc - acc_cyc, 3);
          expect_first = 1'b0;
          byte_in = 0;
        end else begin
          chk($sformatf("start_gap_b%0d", byte_in), cyc - prev_start,
              (byte_in % 9 == 0) ? ENTRY_CYC - 9 * 10 * DIV + 10 * DIV : 10 * DIV);
        end
        prev_start = cyc;
        byte_in++;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt == DIV / 2) begin
        chk("start_bit", int'(tx), 0);
      end else if (dec_cnt < 9 * DIV + DIV / 2 && (dec_cnt - DIV / 2) % DIV == 0) begin
        dec_sh = {tx, dec_sh[7:1]};
      end else if (dec_cnt == 9 * DIV + DIV / 2) begin
        chk("stop_bit", int'(tx), 1);
        chk("exp_available", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0)
          chk($sformatf("byte%0d", rx_count), int'(dec_sh), int'(exp_q.pop_front()));
        rx_count++;
        dec_busy = 1'b0;
      end
    end
  end

  initial begin
    int t;
    int base;
    for (int i = 0; i < DEPTH; i++) rf[i] = 16'(i);
    rf[0]  = 16'h00AB;
    rf[31] = 16'hF00D;

    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ra", int'(ra), 0);
    rst = 1'b0;
    @(negedge clk);

    // first dump: single-cycle start pulse
    push_dump();
    expect_first = 1'b1;
    start = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("ra_first", int'(ra), 0);

    // entry 3 is in SEND: later rd changes must not show in its digits
    wait_rx(30, "wait_entry3");
    rf[3] = 16'hBEEF;

    // start pulse during entry 5 must be ignored
    wait_rx(50, "wait_entry5");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // hold start through done: second dump must follow immediately
    wait_rx(288, "wait_dump1_end");
    start = 1'b1;
    push_dump();
    t = 0;
    while (done_cnt < 1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done_cnt, 1);
    chk("dump_len", done_cyc - acc_cyc, DEPTH * ENTRY_CYC);
    @(negedge clk);
    chk("busy_second_dump", int'(busy), 1);
    start = 1'b0;

    // reset mid-frame in entry 10 of the second dump
    wait_rx(288 + 90, "wait_entry10");
    t = 0;
    while (tx !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("entry10_start_seen", int'(tx), 0);
    repeat (4 * DIV + 4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", int'(tx), 1);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ra", int'(ra), 0);
    chk("post_rst_busy", int'(busy), 0);

    // fresh dump restarts from address 0
    base = rx_count;
    push_dump();
    expect_first = 1'b1;
    start = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_rx(base + 18, "wait_redump");
    chk("done_count", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
